// File: rtl/axi_mem_slave_pkg.sv
// Shared definitions for the memory-backed bus slave: channel field slices,
// response codes, FSM state encodings and small packing helpers.
package axi_mem_slave_pkg;

  // AR channel: {addr[7:0], len[3:0], id[3:0]}
  localparam int unsigned AR_W        = 16;
  localparam int unsigned AR_ADDR_MSB = 15;
  localparam int unsigned AR_ADDR_LSB = 8;
  localparam int unsigned AR_LEN_MSB  = 7;
  localparam int unsigned AR_LEN_LSB  = 4;
  localparam int unsigned AR_ID_MSB   = 3;
  localparam int unsigned AR_ID_LSB   = 0;

  // AW channel: {addr[7:0], id[3:0]}
  localparam int unsigned AW_W        = 12;
  localparam int unsigned AW_ADDR_MSB = 11;
  localparam int unsigned AW_ADDR_LSB = 4;
  localparam int unsigned AW_ID_MSB   = 3;
  localparam int unsigned AW_ID_LSB   = 0;

  // R beat is {data[7:0], resp}; BRESP is {id[3:0], resp}
  localparam int unsigned R_W     = 9;
  localparam int unsigned BRESP_W = 5;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    StRIdle,
    StRData
  } r_state_e;

  typedef enum logic [1:0] {
    StWIdle,
    StWData,
    StWWait,
    StWResp
  } w_state_e;

  // Reduce a 9-bit address sum to a byte index modulo the array depth.
  function automatic logic [7:0] wrap_idx(input logic [8:0] sum, input int unsigned depth);
    return 8'(32'(sum) % depth);
  endfunction

  function automatic logic [R_W-1:0] pack_r(input logic [7:0] data, input logic resp);
    return {data, resp};
  endfunction

  function automatic logic [BRESP_W-1:0] pack_b(input logic [3:0] id, input logic resp);
    return {id, resp};
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Byte-wide storage: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module axi_mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AIDX  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AIDX-1:0] i_waddr,
  input  logic [7:0]      i_wdata,
  input  logic [AIDX-1:0] i_raddr,
  output logic [7:0]      o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write port: the new byte is visible to the read port from the next cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// Memory-backed slave terminating the AR/R read path and the AW/W/B write path.
// The read and write FSMs are independent and share only the byte array.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned MAX_BEATS   = 16,
  parameter int unsigned ERR_ON_WRAP = 0,
  parameter int unsigned B_DELAY     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  // read address / data
  input  logic               i_arvalid,
  input  logic [AR_W-1:0]    i_ar,
  output logic               o_arready,
  output logic               o_rvalid,
  output logic [R_W-1:0]     o_r,
  output logic               o_rlast,
  input  logic               i_rready,
  // write address / data / response
  input  logic               i_awvalid,
  input  logic [AW_W-1:0]    i_aw,
  output logic               o_awready,
  input  logic               i_wvalid,
  input  logic [7:0]         i_wdata,
  input  logic               i_wlast,
  output logic               o_wready,
  output logic               o_bvalid,
  output logic [BRESP_W-1:0] o_bresp,
  input  logic               i_bready
);

  // Addresses are 8 bits wide, so DEPTH is at most 256.
  localparam int unsigned AIDX      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW        = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_B   = BW'(MAX_BEATS);
  localparam logic [8:0] LAST_ADDR  = 9'(DEPTH - 1);
  localparam logic [3:0] DLY_LAST   = 4'((B_DELAY > 0) ? B_DELAY - 1 : 0);

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e    r_rstate, w_rstate_d;
  logic [7:0]  r_raddr;
  logic [3:0]  r_rlen;
  logic [3:0]  r_rid;
  logic [3:0]  r_rbeat;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic [8:0]  w_rsum;
  logic        w_rwrap;
  logic [7:0]  w_rdata;
  logic [AIDX-1:0] w_ridx;

  assign w_rsum  = {1'b0, r_raddr} + {5'b0, r_rbeat};
  assign w_rwrap = (ERR_ON_WRAP != 0) && (w_rsum > LAST_ADDR);
  assign w_ridx  = AIDX'(wrap_idx(w_rsum, DEPTH));
  assign w_ar_hs = i_arvalid & o_arready;
  assign w_r_hs  = o_rvalid & i_rready;

  // ARID is latched but R carries no id field.
  logic w_unused_rid;
  assign w_unused_rid = ^r_rid;

  // Read next-state and channel outputs; R follows the array combinationally.
  always_comb begin
    w_rstate_d = r_rstate;
    o_arready  = 1'b0;
    o_rvalid   = 1'b0;
    o_rlast    = 1'b0;
    o_r        = '0;
    unique case (r_rstate)
      StRIdle: begin
        o_arready = 1'b1;
        if (i_arvalid) begin
          w_rstate_d = StRData;
        end
      end
      StRData: begin
        o_rvalid = 1'b1;
        o_rlast  = (r_rbeat == r_rlen);
        o_r      = w_rwrap ? pack_r(8'h00, RESP_SLVERR) : pack_r(w_rdata, RESP_OKAY);
        if (i_rready && o_rlast) begin
          w_rstate_d = StRIdle;
        end
      end
      default: w_rstate_d = StRIdle;
    endcase
  end

  // Read state, latched request and beat counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rstate <= StRIdle;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rid    <= '0;
      r_rbeat  <= '0;
    end else begin
      r_rstate <= w_rstate_d;
      if (w_ar_hs) begin
        r_raddr <= i_ar[AR_ADDR_MSB:AR_ADDR_LSB];
        r_rlen  <= i_ar[AR_LEN_MSB:AR_LEN_LSB];
        r_rid   <= i_ar[AR_ID_MSB:AR_ID_LSB];
        r_rbeat <= '0;
      end else if (w_r_hs) begin
        r_rbeat <= r_rbeat + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e    r_wstate, w_wstate_d;
  logic [7:0]  r_waddr;
  logic [3:0]  r_wid;
  logic [BW-1:0] r_wbeat;
  logic        r_werr;
  logic [3:0]  r_wdly;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_we;
  logic [8:0]  w_wsum;
  logic [AIDX-1:0] w_widx;

  assign w_wsum  = {1'b0, r_waddr} + 9'(r_wbeat);
  assign w_widx  = AIDX'(wrap_idx(w_wsum, DEPTH));
  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs  = i_wvalid & o_wready;
  // Beats past MAX_BEATS are accepted on the bus but never reach the array.
  assign w_we    = w_w_hs & (r_wbeat < MAX_B);

  // Write next-state and channel outputs.
  always_comb begin
    w_wstate_d = r_wstate;
    o_awready  = 1'b0;
    o_wready   = 1'b0;
    o_bvalid   = 1'b0;
    o_bresp    = '0;
    unique case (r_wstate)
      StWIdle: begin
        o_awready = 1'b1;
        if (i_awvalid) begin
          w_wstate_d = StWData;
        end
      end
      StWData: begin
        o_wready = 1'b1;
        if (i_wvalid && i_wlast) begin
          w_wstate_d = (B_DELAY > 0) ? StWWait : StWResp;
        end
      end
      StWWait: begin
        if (r_wdly == DLY_LAST) begin
          w_wstate_d = StWResp;
        end
      end
      StWResp: begin
        o_bvalid = 1'b1;
        o_bresp  = pack_b(r_wid, r_werr);
        if (i_bready) begin
          w_wstate_d = StWIdle;
        end
      end
      default: w_wstate_d = StWIdle;
    endcase
  end

  // Write state, latched request, saturating beat counter, error and delay count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wstate <= StWIdle;
      r_waddr  <= '0;
      r_wid    <= '0;
      r_wbeat  <= '0;
      r_werr   <= RESP_OKAY;
      r_wdly   <= '0;
    end else begin
      r_wstate <= w_wstate_d;
      if (w_aw_hs) begin
        r_waddr <= i_aw[AW_ADDR_MSB:AW_ADDR_LSB];
        r_wid   <= i_aw[AW_ID_MSB:AW_ID_LSB];
        r_wbeat <= '0;
        r_werr  <= RESP_OKAY;
      end
      if (w_w_hs) begin
        if (r_wbeat < MAX_B) begin
          r_wbeat <= r_wbeat + BW'(1);
        end else begin
          r_werr <= RESP_SLVERR;
        end
      end
      if (w_w_hs && i_wlast) begin
        r_wdly <= '0;
      end else if (r_wstate == StWWait) begin
        r_wdly <= r_wdly + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  axi_mem_array #(
    .DEPTH (DEPTH),
    .AIDX  (AIDX)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (i_wdata),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a byte-array model.
module tb_axi_mem_slave;

  localparam int unsigned DEPTH    = 256;
  localparam int unsigned MAXB     = 16;
  localparam int unsigned ERR_WRAP = 1;
  localparam int unsigned BDLY     = 2;

  logic        clk;
  logic        rst;
  logic        arvalid;
  logic [15:0] ar;
  logic        arready;
  logic        rvalid;
  logic [8:0]  r;
  logic        rlast;
  logic        rready;
  logic        awvalid;
  logic [11:0] aw;
  logic        awready;
  logic        wvalid;
  logic [7:0]  wdata;
  logic        wlast;
  logic        wready;
  logic        bvalid;
  logic [4:0]  bresp;
  logic        bready;

  logic [7:0] tb_mem [DEPTH];
  int n_cmp;
  int n_err;

  axi_mem_slave #(
    .DEPTH       (DEPTH),
    .MAX_BEATS   (MAXB),
    .ERR_ON_WRAP (ERR_WRAP),
    .B_DELAY     (BDLY)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_arvalid (arvalid),
    .i_ar      (ar),
    .o_arready (arready),
    .o_rvalid  (rvalid),
    .o_r       (r),
    .o_rlast   (rlast),
    .i_rready  (rready),
    .i_awvalid (awvalid),
    .i_aw      (aw),
    .o_awready (awready),
    .i_wvalid  (wvalid),
    .i_wdata   (wdata),
    .i_wlast   (wlast),
    .o_wready  (wready),
    .o_bvalid  (bvalid),
    .o_bresp   (bresp),
    .i_bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write burst of n beats; base < 0 gives random bytes, else base+i.
  task automatic wr_burst(input logic [7:0] addr, input logic [3:0] id, input int n,
                          input int base);
    logic       err;
    logic [7:0] d;
    int         cnt;
    @(negedge clk);
    awvalid = 1'b1;
    aw      = {addr, id};
    // A beat offered while idle must be ignored.
    wvalid  = 1'b1;
    wdata   = 8'hEE;
    wlast   = 1'b1;
    check_val("aw_ready", awready, 1);
    check_val("w_ready_idle", wready, 0);
    err = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      awvalid = 1'b0;
      for (int s = 0; s < 2 && $urandom_range(3) == 0; s++) begin
        wvalid = 1'b0;
        wlast  = 1'b0;
        check_val("aw_ready_busy", awready, 0);
        @(negedge clk);
      end
      d      = (base < 0) ? 8'($urandom) : 8'(base + i);
      wvalid = 1'b1;
      wdata  = d;
      wlast  = (i == n - 1);
      check_val("w_ready", wready, 1);
      if (i < int'(MAXB)) tb_mem[(int'(addr) + i) % DEPTH] = d;
      else err = 1'b1;
    end
    @(negedge clk);
    wvalid = 1'b0;
    wlast  = 1'b0;
    cnt    = 0;
    while (!bvalid && cnt < 40) begin
      check_val("w_ready_after_last", wready, 0);
      cnt++;
      @(negedge clk);
    end
    check_val("b_latency", cnt, BDLY);
    check_val("bresp", bresp, {id, err});
    repeat ($urandom_range(2)) begin
      @(negedge clk);
      check_val("b_hold_valid", bvalid, 1);
      check_val("b_hold_resp", bresp, {id, err});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("b_done_valid", bvalid, 0);
    check_val("b_done_awready", awready, 1);
  endtask

  // Read burst of len+1 beats; RREADY is always high or randomly stalled.
  task automatic rd_burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input bit full_rate);
    int         beat;
    int         guard;
    int         sum;
    logic [8:0] exp_r;
    @(negedge clk);
    arvalid = 1'b1;
    ar      = {addr, len, id};
    rready  = 1'b0;
    check_val("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    beat    = 0;
    guard   = 0;
    while (beat <= int'(len) && guard < 200) begin
      sum   = int'(addr) + beat;
      exp_r = (ERR_WRAP != 0 && sum > int'(DEPTH) - 1) ? 9'h001 : {tb_mem[sum % DEPTH], 1'b0};
      check_val("r_valid", rvalid, 1);
      check_val("r_data", r, exp_r);
      check_val("r_last", rlast, beat == int'(len));
      check_val("ar_ready_busy", arready, 0);
      rready = full_rate ? 1'b1 : ($urandom_range(2) != 0);
      if (rready) beat++;
      guard++;
      @(negedge clk);
    end
    rready = 1'b0;
    check_val("r_beats", beat, int'(len) + 1);
    check_val("r_done_valid", rvalid, 0);
    check_val("r_done_arready", arready, 1);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    arvalid = 1'b0;
    ar      = '0;
    rready  = 1'b0;
    awvalid = 1'b0;
    aw      = '0;
    wvalid  = 1'b0;
    wdata   = '0;
    wlast   = 1'b0;
    bready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_arready", arready, 1);
    check_val("rst_awready", awready, 1);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_r", r, 0);
    check_val("rst_rlast", rlast, 0);
    check_val("rst_wready", wready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_bresp", bresp, 0);

    // Fill the whole array so every later read has a known expectation.
    for (int k = 0; k < 16; k++) wr_burst(8'(k * 16), 4'(k), 16, -1);

    // Directed bursts.
    wr_burst(8'h10, 4'h3, 4, 'hA0);
    rd_burst(8'h10, 4'd3, 4'h3, 1'b1);
    rd_burst(8'h10, 4'd2, 4'h1, 1'b0);
    wr_burst(8'hFE, 4'h7, 3, -1);
    rd_burst(8'hFE, 4'd2, 4'h7, 1'b0);
    rd_burst(8'h00, 4'd0, 4'h7, 1'b1);
    wr_burst(8'h50, 4'h5, 18, -1);
    rd_burst(8'h50, 4'd15, 4'h5, 1'b0);
    rd_burst(8'h60, 4'd1, 4'h5, 1'b1);

    // AR and AW accepted in the same cycle, disjoint addresses.
    fork
      rd_burst(8'h30, 4'd5, 4'h2, 1'b0);
      wr_burst(8'hA0, 4'h6, 5, -1);
    join

    // Reset during beat 2 of an 8-beat read.
    @(negedge clk);
    arvalid = 1'b1;
    ar      = {8'h40, 4'd7, 4'h1};
    @(negedge clk);
    arvalid = 1'b0;
    rready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_mid_beat2", r, {tb_mem[8'h42], 1'b0});
    rst    = 1'b1;
    rready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_rvalid", rvalid, 0);
    check_val("rst_mid_arready", arready, 1);
    check_val("rst_mid_awready", awready, 1);

    // Reset part-way through a write: no response ever appears.
    @(negedge clk);
    awvalid = 1'b1;
    aw      = {8'h80, 4'h9};
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = 8'h5A;
    wlast   = 1'b0;
    tb_mem[8'h80] = 8'h5A;
    @(negedge clk);
    wdata = 8'hA5;
    tb_mem[8'h81] = 8'hA5;
    @(negedge clk);
    wvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_val("rst_w_bvalid", bvalid, 0);
      check_val("rst_w_awready", awready, 1);
      check_val("rst_w_wready", wready, 0);
      @(negedge clk);
    end
    rd_burst(8'h40, 4'd7, 4'h1, 1'b1);
    rd_burst(8'h80, 4'd1, 4'h9, 1'b1);

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1) != 0) begin
        wr_burst(8'($urandom), 4'($urandom), int'($urandom_range(1, 20)), -1);
      end else begin
        rd_burst(8'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
Memory-backed slave that terminates both channels of the team's bus master: the AR/R read path and the AW/W/B write path.
- Holds a 256-byte array.
- Accepts one read burst and one write burst independently; the two channels run concurrently.
- Returns read beats as the packed {data, resp} word the master consumes.
- Returns a packed {id, resp} write response.
- Sits directly downstream of the master in the bus testbench and system.

Parameters:
DEPTH, 256, number of byte locations; addresses wrap modulo DEPTH.
MAX_BEATS, 16, longest legal write burst; beat MAX_BEATS+1 onward is dropped and flagged.
ERR_ON_WRAP, 0, if 1 a read beat whose address wrapped past DEPTH-1 returns RRESP=1 and data 0.
B_DELAY, 0, extra idle cycles between accepting the WLAST beat and raising BVALID (0..15).

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
ARVALID  in  1  read address valid
AR  in  16  [15:8] ARADDR, [7:4] ARLEN (beats-1), [3:0] ARID
ARREADY  out  1  read address accept
RVALID  out  1  read beat valid
R  out  9  [8:1] RDATA, [0] RRESP
RLAST  out  1  final read beat
RREADY  in  1  master accepts read beat
AWVALID  in  1  write address valid
AW  in  12  [11:4] AWADDR, [3:0] AWID
AWREADY  out  1  write address accept
WVALID  in  1  write beat valid
WDATA  in  8  write byte
WLAST  in  1  final write beat
WREADY  out  1  slave accepts write beat
BVALID  out  1  write response valid
BRESP  out  5  [4:1] AWID echo, [0] 0=OKAY, 1=SLVERR
BREADY  in  1  master accepts response

Behaviour:
Reset:
- Both FSMs go to IDLE; all outputs are 0 except ARREADY=1 and AWREADY=1.
- Beat counters and latched address/len/id are cleared.
- Memory contents are retained.
- A reset mid-burst abandons the burst with no response.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch addr/len/id, clear beat counter, go to R_DATA. ARREADY=0 from the next cycle.
- R_DATA: RVALID=1 starting the cycle after the AR handshake (1-cycle latency). R={mem[(addr+beat)%DEPTH], resp}. RLAST=1 when beat==len.
- R, RLAST and RVALID hold stable while RVALID&!RREADY.
- On RVALID&RREADY: beat+1, and the new data is presented next cycle. If RLAST, go to R_IDLE, with RVALID=0 and ARREADY=1 next cycle.
- len=0 gives a single beat with RLAST=1.
- Beat counter is 4-bit; address adds are 8-bit and wrap. RRESP=1 only when ERR_ON_WRAP=1 and addr+beat>DEPTH-1.

Write FSM (W_IDLE, W_DATA, W_WAIT, W_RESP):
- W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch addr/id, clear beat counter and err, go to W_DATA. AWREADY=0 from the next cycle.
- W_DATA: WREADY=1. On WVALID&WREADY:
  - if beat<MAX_BEATS, write mem[(addr+beat)%DEPTH]=WDATA; otherwise discard the byte and set err.
  - beat+1, saturating at MAX_BEATS.
- On a WLAST beat: go to W_WAIT if B_DELAY>0, else go to W_RESP; WREADY=0 next cycle.
- W_WAIT: count B_DELAY cycles, then go to W_RESP.
- W_RESP: BVALID=1, BRESP={id, err}, held stable until BREADY. On BVALID&BREADY go to W_IDLE, with AWREADY=1 next cycle.
- WVALID with WREADY=0 is ignored and not stored.

Simultaneous events:
- Read and write in the same cycle to the same address: the read beat presented that cycle shows the old byte; the new byte is visible from the next cycle.
- AR and AW handshakes in the same cycle are both accepted.

Decomposition:
Shared package:
- Field-slice constants for AR/AW/R/BRESP packing.
- RESP_OKAY=0, RESP_SLVERR=1.
- Read and write state encodings.

Sub-module: axi_mem_array (single write port, asynchronous read port, DEPTH x 8) instantiated once. The read and write FSMs live in the top module.

Test Plan:
1. Write AW addr=0x10 id=0x3, bytes 0xA0..0xA3 with WLAST on the 4th -> bytes stored at 0x10-0x13; BRESP=0x06 ({3,0}); BVALID held until BREADY.
2. Read AR=0x1033 (addr 0x10, len 3, id 3) with RREADY=1 -> four beats R=0x140,0x142,0x144,0x146 on consecutive cycles; RLAST only on the 4th; RVALID first high 1 cycle after the handshake.
3. Read len=2 with RREADY toggled 1-0-1 -> R and RLAST held stable during the stall; exactly 3 beats delivered.
4. Write addr=0xFE, 3 bytes -> stored at 0xFE, 0xFF, 0x00. Read back 3 beats with ERR_ON_WRAP=1 -> third beat R=0x001.
5. Write burst of 18 beats with id=0x5 -> only first 16 bytes stored; BRESP=0x0B.
6. Assert rst during read beat 2 of a len=7 burst -> next cycle RVALID=0, ARREADY=1, AWREADY=1. A following read returns the pre-reset memory contents.
